// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, overlay digit indices and BCD helpers
// for the clock-display overlay path.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned NUM_DIGITS = 6;

   typedef enum logic [2:0] {
      DIG_H1 = 3'd0,
      DIG_H0 = 3'd1,
      DIG_M1 = 3'd2,
      DIG_M0 = 3'd3,
      DIG_S1 = 3'd4,
      DIG_S0 = 3'd5
   } digit_e;

   // Digit 0 (h1) lives in the most significant nibble of the 24-bit time word.
   function automatic logic [3:0] bcd_nibble(input logic [23:0] t, input logic [2:0] d);
      logic [4:0] lsb;
      lsb = 5'(20 - 4 * int'(d));
      return t[lsb +: 4];
   endfunction

   function automatic int unsigned digit_start(input int unsigned x0,
                                               input int unsigned pitch,
                                               input int unsigned gap,
                                               input int unsigned d);
      return x0 + d * pitch + (d >> 1) * gap;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync window
// decoded from the position the counter is about to take.
module vga_axis_counter #(
   parameter int unsigned TOTAL      = 800,
   parameter int unsigned SYNC_START = 656,
   parameter int unsigned SYNC_WIDTH = 96,
   parameter logic        SYNC_POL   = 1'b0,
   parameter int unsigned W          = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         carry_in,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         wrap,
   output logic         sync
);

   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
   localparam logic [W-1:0] SYNC_HI = W'(SYNC_START + SYNC_WIDTH);

   always_comb begin
      wrap      = en && carry_in && (count == LAST);
      count_nxt = count;
      if (en && carry_in) begin
         count_nxt = wrap ? '0 : count + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= LAST;
         sync  <= ~SYNC_POL;
      end else if (en) begin
         count <= count_nxt;
         sync  <= (count_nxt >= SYNC_LO && count_nxt < SYNC_HI) ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/vga_overlay_sequencer.sv
// VGA raster timing plus HH:MM:SS overlay scheduler: per pixel reports the digit
// under the beam, its frame-stable BCD value and glyph-relative row/column.
module vga_overlay_sequencer
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter logic        SYNC_POL    = 1'b0,
   parameter int unsigned OVL_X0      = 295,
   parameter int unsigned OVL_Y0      = 235,
   parameter int unsigned DIGIT_W     = 5,
   parameter int unsigned DIGIT_H     = 9,
   parameter int unsigned DIGIT_PITCH = 8,
   parameter int unsigned PAIR_GAP    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   input  logic [23:0] time_in,
   input  logic        time_valid,
   output logic        h_sinc,
   output logic        v_sinc,
   output logic        active,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        frame_start,
   output logic        ovl_hit,
   output logic [2:0]  digit_idx,
   output logic [3:0]  digit_bcd,
   output logic [2:0]  glyph_col,
   output logic [3:0]  glyph_row
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned LAST_START = digit_start(OVL_X0, DIGIT_PITCH, PAIR_GAP, NUM_DIGITS - 1);

   localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] Y_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] Y_OVL0 = 11'(OVL_Y0);
   localparam logic [10:0] Y_OVL1 = 11'(OVL_Y0 + DIGIT_H);

   if (LAST_START + DIGIT_W > H_ACTIVE || OVL_Y0 + DIGIT_H > V_ACTIVE) begin : g_geom_check
      $error("vga_overlay_sequencer: overlay does not fit inside the visible area");
   end

   logic [10:0] x_nxt;
   logic [10:0] y_nxt;
   logic        h_wrap;
   logic        v_wrap;

   vga_axis_counter #(
      .TOTAL      (H_TOT),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_WIDTH (H_SYNC),
      .SYNC_POL   (SYNC_POL),
      .W          (11)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pix_en),
      .carry_in  (1'b1),
      .count     (pix_x),
      .count_nxt (x_nxt),
      .wrap      (h_wrap),
      .sync      (h_sinc)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOT),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_WIDTH (V_SYNC),
      .SYNC_POL   (SYNC_POL),
      .W          (11)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pix_en),
      .carry_in  (h_wrap),
      .count     (pix_y),
      .count_nxt (y_nxt),
      .wrap      (v_wrap),
      .sync      (v_sinc)
   );

   logic [23:0] snap_q;
   logic [23:0] stage_q;
   logic        pend_q;
   logic        commit;

   // Snapshot swaps exactly when the beam enters the first blanking line.
   assign commit = pix_en && (x_nxt == '0) && (y_nxt == Y_ACT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_q  <= '0;
         stage_q <= '0;
         pend_q  <= 1'b0;
      end else if (commit) begin
         if (time_valid) begin
            snap_q  <= time_in;
            stage_q <= time_in;
         end else if (pend_q) begin
            snap_q <= stage_q;
         end
         pend_q <= 1'b0;
      end else if (time_valid) begin
         stage_q <= time_in;
         pend_q  <= 1'b1;
      end
   end

   logic       act_nxt;
   logic       hit_nxt;
   logic [2:0] idx_nxt;
   logic [3:0] bcd_nxt;
   logic [2:0] col_nxt;
   logic [3:0] row_nxt;

   always_comb begin
      act_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
      hit_nxt = 1'b0;
      idx_nxt = '0;
      bcd_nxt = '0;
      col_nxt = '0;
      row_nxt = '0;
      if (act_nxt && y_nxt >= Y_OVL0 && y_nxt < Y_OVL1) begin
         for (int unsigned d = int'(DIG_H1); d <= int'(DIG_S0); d++) begin
            if (x_nxt >= 11'(digit_start(OVL_X0, DIGIT_PITCH, PAIR_GAP, d)) &&
                x_nxt <  11'(digit_start(OVL_X0, DIGIT_PITCH, PAIR_GAP, d) + DIGIT_W)) begin
               hit_nxt = 1'b1;
               idx_nxt = 3'(d);
               bcd_nxt = bcd_nibble(snap_q, 3'(d));
               col_nxt = 3'(x_nxt - 11'(digit_start(OVL_X0, DIGIT_PITCH, PAIR_GAP, d)));
               row_nxt = 4'(y_nxt - Y_OVL0);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active      <= 1'b0;
         frame_start <= 1'b0;
         ovl_hit     <= 1'b0;
         digit_idx   <= '0;
         digit_bcd   <= '0;
         glyph_col   <= '0;
         glyph_row   <= '0;
      end else if (pix_en) begin
         active      <= act_nxt;
         frame_start <= v_wrap;
         ovl_hit     <= hit_nxt;
         digit_idx   <= idx_nxt;
         digit_bcd   <= bcd_nxt;
         glyph_col   <= col_nxt;
         glyph_row   <= row_nxt;
      end
   end

endmodule

// File: tb/tb_vga_overlay_sequencer.sv
// Scoreboard bench for vga_overlay_sequencer; the vertical raster is shortened
// through parameter overrides so several whole frames fit in a short run.
module tb_vga_overlay_sequencer;

   localparam int unsigned HT = 800;
   localparam int unsigned VA = 14;
   localparam int unsigned VF = 1;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 1;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned OY = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b0;
   logic [23:0] time_in = '0;
   logic        time_valid = 1'b0;
   logic        h_sinc, v_sinc, active, frame_start, ovl_hit;
   logic [10:0] pix_x, pix_y;
   logic [2:0]  digit_idx, glyph_col;
   logic [3:0]  digit_bcd, glyph_row;

   vga_overlay_sequencer #(
      .V_ACTIVE (VA),
      .V_FP     (VF),
      .V_SYNC   (VS),
      .V_BP     (VB),
      .OVL_Y0   (OY)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .time_in     (time_in),
      .time_valid  (time_valid),
      .h_sinc      (h_sinc),
      .v_sinc      (v_sinc),
      .active      (active),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .ovl_hit     (ovl_hit),
      .digit_idx   (digit_idx),
      .digit_bcd   (digit_bcd),
      .glyph_col   (glyph_col),
      .glyph_row   (glyph_row)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hs, vs, act, fs, hit;
      logic [10:0] x, y;
      logic [2:0]  idx, col;
      logic [3:0]  bcd, row;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   int          checks = 0;
   int          errors = 0;
   int          mx, my;
   logic [23:0] snap, stg, shown;
   logic        pend;
   int          st[6] = '{295, 303, 313, 321, 331, 339};

   logic stat_line0 = 1'b0, stat_frame = 1'b0;
   int   hs_cnt = 0, hs_min = 9999, hs_max = -1, act_cnt = 0, fs0_cnt = 0, fs0_x = -1;
   int   fs_cnt = 0, vs_cnt = 0, vs_min = 9999, vs_max = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, mx, my, obs, expv);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.x   = 11'(mx);
      e.y   = 11'(my);
      e.hs  = !(mx >= 656 && mx < 752);
      e.vs  = !(my >= int'(VA + VF) && my < int'(VA + VF + VS));
      e.act = (mx < 640) && (my < int'(VA));
      e.fs  = (mx == 0) && (my == 0);
      e.hit = 1'b0;
      e.idx = '0; e.bcd = '0; e.col = '0; e.row = '0;
      if (e.act && my >= int'(OY) && my < int'(OY + 9)) begin
         for (int k = 0; k < 6; k++) begin
            if (mx >= st[k] && mx < st[k] + 5) begin
               e.hit = 1'b1;
               e.idx = 3'(k);
               e.col = 3'(mx - st[k]);
               e.row = 4'(my - int'(OY));
               e.bcd = snap[(5 - k) * 4 +: 4];
            end
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      mx = HT - 1; my = VT - 1;
      snap = '0; stg = '0; pend = 1'b0;
      cur = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, hit: 1'b0,
              x: 11'(HT - 1), y: 11'(VT - 1), idx: '0, col: '0, bcd: '0, row: '0};
   endtask

   task automatic check_reset();
      check("rst_x", pix_x, HT - 1);
      check("rst_y", pix_y, VT - 1);
      check("rst_hs", h_sinc, 1);
      check("rst_vs", v_sinc, 1);
      check("rst_act", active, 0);
      check("rst_fs", frame_start, 0);
      check("rst_hit", ovl_hit, 0);
      check("rst_idx", digit_idx, 0);
      check("rst_bcd", digit_bcd, 0);
      check("rst_col", glyph_col, 0);
      check("rst_row", glyph_row, 0);
   endtask

   task automatic compare();
      exp_t e;
      if (q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         return;
      end
      e = q.pop_front();
      check("pix_x", pix_x, e.x);
      check("pix_y", pix_y, e.y);
      check("h_sinc", h_sinc, e.hs);
      check("v_sinc", v_sinc, e.vs);
      check("active", active, e.act);
      check("frame_start", frame_start, e.fs);
      check("ovl_hit", ovl_hit, e.hit);
      check("digit_idx", digit_idx, e.idx);
      check("digit_bcd", digit_bcd, e.bcd);
      check("glyph_col", glyph_col, e.col);
      check("glyph_row", glyph_row, e.row);
      if (e.y == 11'(OY + 4)) begin
         if (e.x == 11'd303) begin
            check("geo303_hit", ovl_hit, 1);
            check("geo303_idx", digit_idx, 1);
            check("geo303_col", glyph_col, 0);
            check("geo303_row", glyph_row, 4);
         end
         if (e.x inside {11'd300, 11'd301, 11'd302, 11'd311, 11'd312})
            check("geo_gap_hit", ovl_hit, 0);
      end
      if (e.y == 11'(OY + 9) && e.x == 11'd295) check("geo_below_hit", ovl_hit, 0);
      if (e.y == 11'(OY)) begin
         for (int k = 0; k < 6; k++)
            if (e.x == 11'(st[k])) check("shown_digit", digit_bcd, 32'(shown[(5 - k) * 4 +: 4]));
      end
      if (stat_line0 && pix_y == 0) begin
         if (!h_sinc) begin
            hs_cnt++;
            if (int'(pix_x) < hs_min) hs_min = int'(pix_x);
            if (int'(pix_x) > hs_max) hs_max = int'(pix_x);
         end
         if (active) act_cnt++;
         if (frame_start) begin fs0_cnt++; fs0_x = int'(pix_x); end
      end
      if (stat_frame) begin
         if (frame_start) fs_cnt++;
         if (!v_sinc) begin
            vs_cnt++;
            if (int'(pix_y) < vs_min) vs_min = int'(pix_y);
            if (int'(pix_y) > vs_max) vs_max = int'(pix_y);
         end
      end
   endtask

   task automatic step(input logic pe, input logic tv, input logic [23:0] tin);
      int   nx, ny;
      logic commit;
      pix_en = pe; time_valid = tv; time_in = tin;
      nx = mx; ny = my;
      if (pe) begin
         if (mx == int'(HT - 1)) begin
            nx = 0;
            ny = (my == int'(VT - 1)) ? 0 : my + 1;
         end else begin
            nx = mx + 1;
         end
      end
      commit = pe && nx == 0 && ny == int'(VA);
      if (commit) begin
         if (tv) snap = tin;
         else if (pend) snap = stg;
         pend = 1'b0;
      end else if (tv) begin
         stg = tin; pend = 1'b1;
      end
      if (pe) begin
         mx = nx; my = ny;
         cur = model_out();
      end
      q.push_back(cur);
      @(posedge clk); #1;
      compare();
      time_valid = 1'b0;
   endtask

   task automatic run_to(input int x, input int y);
      int n = 0;
      while (!(mx == x && my == y)) begin
         step(1'b1, 1'b0, '0);
         n++;
         if (n > 20000) begin
            check("run_to_timeout", 0, 1);
            break;
         end
      end
   endtask

   initial begin
      model_reset();
      shown = '0;
      rst_n = 1'b0; pix_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;

      stat_line0 = 1'b1; stat_frame = 1'b1;
      for (int i = 0; i < 800; i++) step(1'b1, 1'b0, '0);
      stat_line0 = 1'b0;
      check("line0_hs_cnt", hs_cnt, 96);
      check("line0_hs_min", hs_min, 656);
      check("line0_hs_max", hs_max, 751);
      check("line0_act_cnt", act_cnt, 640);
      check("line0_fs_cnt", fs0_cnt, 1);
      check("line0_fs_x", fs0_x, 0);

      run_to(100, 2);
      step(1'b1, 1'b1, 24'h123456);
      run_to(HT - 1, VT - 1);
      stat_frame = 1'b0;
      check("frame_fs_cnt", fs_cnt, 1);
      check("frame_vs_cnt", vs_cnt, 2 * HT);
      check("frame_vs_min", vs_min, VA + VF);
      check("frame_vs_max", vs_max, VA + VF + 1);

      shown = 24'h123456;
      step(1'b1, 1'b0, '0);
      check("wrap_x", pix_x, 0);
      check("wrap_y", pix_y, 0);
      check("wrap_fs", frame_start, 1);
      run_to(50, 2);
      step(1'b0, 1'b1, 24'h111111);
      run_to(HT - 1, VA - 1);
      step(1'b1, 1'b1, 24'h235959);
      run_to(HT - 1, VT - 1);

      shown = 24'h235959;
      step(1'b1, 1'b0, '0);
      run_to(HT - 1, VT - 1);
      step(1'b1, 1'b0, '0);
      run_to(200, OY + 1);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0);
      run_to(400, OY + 6);

      rst_n = 1'b0; pix_en = 1'b0;
      @(posedge clk); #1;
      check_reset();
      model_reset();
      q.delete();
      rst_n = 1'b1;
      shown = '0;
      step(1'b1, 1'b0, '0);
      check("rel_x", pix_x, 0);
      check("rel_y", pix_y, 0);
      check("rel_fs", frame_start, 1);
      run_to(HT - 1, OY + 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
